// File: rtl/mem_stage_wbuf_pkg.sv
// Shared types and constants for the memory-stage write buffer.
// The buffer entry struct is sized by the package widths. The top-level
// DATA_W/ADDR_W parameters default to the same values.
package mem_stage_wbuf_pkg;

    localparam int PKG_DATA_W = 32;
    localparam int PKG_ADDR_W = 32;
    localparam logic [PKG_ADDR_W-1:0] PKG_BASE_ADDR = 32'd1024;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2
    } state_t;

    typedef struct packed {
        logic [PKG_ADDR_W-1:0] addr;
        logic [PKG_DATA_W-1:0] data;
    } wbuf_entry_t;

    // Word-align a byte address, then rebase it into the controller's space.
    // The subtraction wraps modulo 2^ADDR_W.
    function automatic logic [PKG_ADDR_W-1:0] translateAddr(
        input logic [PKG_ADDR_W-1:0] byteAddr,
        input logic [PKG_ADDR_W-1:0] baseAddr
    );
        return {byteAddr[PKG_ADDR_W-1:2], 2'b00} - baseAddr;
    endfunction

endpackage

// File: rtl/mem_stage_wbuf_if.sv
// Request/acknowledge bus between the memory stage and the SRAM controller.
// The stage is the master. The controller is the slave.
interface mem_stage_wbuf_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_ack,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_ack,
        output mem_rdata
    );

endinterface

// File: rtl/wbuf_fifo.sv
// Circular write buffer with an associative lookup.
// The lookup returns the data of the youngest valid entry whose address
// matches. The head entry stays visible to the lookup until it is popped.
module wbuf_fifo
    import mem_stage_wbuf_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          i_push,
    input  wbuf_entry_t                   i_pushEntry,
    input  logic                          i_pop,
    output wbuf_entry_t                   o_headEntry,
    output logic [$clog2(DEPTH):0]        o_count,
    output logic                          o_empty,
    output logic                          o_full,
    input  logic [PKG_ADDR_W-1:0]         i_lookupAddr,
    output logic                          o_hit,
    output logic [PKG_DATA_W-1:0]         o_hitData
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    wbuf_entry_t       r_entries [DEPTH];
    logic [PTR_W-1:0]  r_head;
    logic [PTR_W-1:0]  r_tail;
    logic [CNT_W-1:0]  r_count;
    logic [PTR_W-1:0]  w_idx;

    // Pointers wrap naturally. A simultaneous push and pop leaves the count unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) begin
                r_tail <= r_tail + 1'b1;
            end
            if (i_pop) begin
                r_head <= r_head + 1'b1;
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage needs no reset. Reset clears the count, so stale entries are never valid.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_entries[r_tail] <= i_pushEntry;
        end
    end

    assign o_headEntry = r_entries[r_head];
    assign o_count     = r_count;
    assign o_empty     = (r_count == '0);
    assign o_full      = (r_count == CNT_W'(DEPTH));

    // Walk from oldest to youngest so that a later match overrides an earlier one.
    always_comb begin
        o_hit     = 1'b0;
        o_hitData = '0;
        w_idx     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_idx = r_head + PTR_W'(i);
            if ((CNT_W'(i) < r_count) && (r_entries[w_idx].addr == i_lookupAddr)) begin
                o_hit     = 1'b1;
                o_hitData = r_entries[w_idx].data;
            end
        end
    end

endmodule

// File: rtl/mem_stage_wbuf.sv
// Memory-stage front end.
// Stores are posted into a write buffer, and the buffer drains to the SRAM
// controller in the background. A load that hits the buffer is forwarded in
// the same cycle. A load miss freezes the pipeline until the controller
// returns the data.
module mem_stage_wbuf
    import mem_stage_wbuf_pkg::*;
#(
    parameter int                  DATA_W     = PKG_DATA_W,
    parameter int                  ADDR_W     = PKG_ADDR_W,
    parameter int                  REG_ADDR_W = 4,
    parameter int                  DEPTH      = 4,
    parameter logic [ADDR_W-1:0]   BASE_ADDR  = PKG_BASE_ADDR
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_wb_en,
    input  logic                   i_mem_r_en,
    input  logic                   i_mem_w_en,
    input  logic [ADDR_W-1:0]      i_alu_res,
    input  logic [DATA_W-1:0]      i_val_rm,
    input  logic [REG_ADDR_W-1:0]  i_dest,
    output logic                   o_wb_en,
    output logic                   o_mem_r_en,
    output logic [ADDR_W-1:0]      o_alu_res,
    output logic [REG_ADDR_W-1:0]  o_dest,
    output logic [DATA_W-1:0]      o_mem_out,
    output logic                   o_ready,
    output logic                   o_wbuf_empty,
    mem_stage_wbuf_if.master       memBus
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    state_t             r_state;
    state_t             w_nextState;

    logic               r_memReq;
    logic               r_memWe;
    logic [ADDR_W-1:0]  r_memAddr;
    logic [DATA_W-1:0]  r_memWdata;

    logic [ADDR_W-1:0]  w_effAddr;
    wbuf_entry_t        w_pushEntry;
    wbuf_entry_t        w_headEntry;
    logic [CNT_W-1:0]   w_count;
    logic               w_empty;
    logic               w_full;
    logic               w_hit;
    logic [DATA_W-1:0]  w_hitData;
    logic               w_push;
    logic               w_pop;
    logic               w_loadMiss;
    logic               w_ackValid;
    logic               w_issueRead;
    logic               w_issueWrite;
    logic               w_readDone;

    assign o_wb_en    = i_wb_en;
    assign o_mem_r_en = i_mem_r_en;
    assign o_alu_res  = i_alu_res;
    assign o_dest     = i_dest;

    assign w_effAddr   = translateAddr(i_alu_res, BASE_ADDR);
    assign w_pushEntry = '{addr: w_effAddr, data: i_val_rm};

    // A full buffer rejects the store even if the head leaves in this same cycle.
    assign w_push     = i_mem_w_en & ~w_full;
    assign w_loadMiss = i_mem_r_en & ~w_hit;
    assign w_ackValid = memBus.mem_ack & r_memReq;

    wbuf_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_push       (w_push),
        .i_pushEntry  (w_pushEntry),
        .i_pop        (w_pop),
        .o_headEntry  (w_headEntry),
        .o_count      (w_count),
        .o_empty      (w_empty),
        .o_full       (w_full),
        .i_lookupAddr (w_effAddr),
        .o_hit        (w_hit),
        .o_hitData    (w_hitData)
    );

    // State register for the controller transaction sequencer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic. Reads beat draining, and an in-flight transaction always runs to its ack.
    always_comb begin
        w_nextState  = r_state;
        w_issueRead  = 1'b0;
        w_issueWrite = 1'b0;
        w_pop        = 1'b0;
        w_readDone   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_loadMiss) begin
                    w_nextState = ST_READ;
                    w_issueRead = 1'b1;
                end else if (!w_empty) begin
                    w_nextState  = ST_WRITE;
                    w_issueWrite = 1'b1;
                end
            end
            ST_WRITE: begin
                if (w_ackValid) begin
                    w_nextState = ST_IDLE;
                    w_pop       = 1'b1;
                end
            end
            ST_READ: begin
                if (w_ackValid) begin
                    w_nextState = ST_IDLE;
                    w_readDone  = 1'b1;
                end
            end
            default: begin
                w_nextState = ST_IDLE;
            end
        endcase
    end

    // Request registers load when leaving IDLE. The request drops on the edge that closes the ack cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_memReq   <= 1'b0;
            r_memWe    <= 1'b0;
            r_memAddr  <= '0;
            r_memWdata <= '0;
        end else if (w_issueRead) begin
            r_memReq   <= 1'b1;
            r_memWe    <= 1'b0;
            r_memAddr  <= w_effAddr;
            r_memWdata <= '0;
        end else if (w_issueWrite) begin
            r_memReq   <= 1'b1;
            r_memWe    <= 1'b1;
            r_memAddr  <= w_headEntry.addr;
            r_memWdata <= w_headEntry.data;
        end else if (w_ackValid) begin
            r_memReq   <= 1'b0;
        end
    end

    assign memBus.mem_req   = r_memReq;
    assign memBus.mem_we    = r_memWe;
    assign memBus.mem_addr  = r_memAddr;
    assign memBus.mem_wdata = r_memWdata;

    // Freeze the pipeline on a store into a full buffer, or on a load miss until its read ack arrives.
    assign o_ready      = ~(i_mem_w_en & w_full) & ~(w_loadMiss & ~w_readDone);
    assign o_wbuf_empty = w_empty & (r_state != ST_WRITE);

    // The load result is either forwarded from the buffer or taken from the controller in the ack cycle.
    always_comb begin
        o_mem_out = '0;
        if (i_mem_r_en && w_hit) begin
            o_mem_out = w_hitData;
        end else if (i_mem_r_en && w_readDone) begin
            o_mem_out = memBus.mem_rdata;
        end
    end

endmodule

// File: tb/tb_mem_stage_wbuf.sv
// Self-checking bench for mem_stage_wbuf.
// A queue-based model of the buffer and a sparse memory model predict the
// outputs on every cycle. Directed scenarios add literal expectations.
module tb_mem_stage_wbuf;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        wbEn, rEn, wEn;
   logic [31:0] aluRes, valRm;
   logic [3:0]  dest;
   logic        wbEnOut, rEnOut;
   logic [31:0] aluResOut, memOut;
   logic [3:0]  destOut;
   logic        ready, wbufEmpty;

   mem_stage_wbuf_if #(.ADDR_W(32), .DATA_W(32)) memBus();

   mem_stage_wbuf #(
      .DATA_W     (32),
      .ADDR_W     (32),
      .REG_ADDR_W (4),
      .DEPTH      (DEPTH),
      .BASE_ADDR  (32'd1024)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_wb_en      (wbEn),
      .i_mem_r_en   (rEn),
      .i_mem_w_en   (wEn),
      .i_alu_res    (aluRes),
      .i_val_rm     (valRm),
      .i_dest       (dest),
      .o_wb_en      (wbEnOut),
      .o_mem_r_en   (rEnOut),
      .o_alu_res    (aluResOut),
      .o_dest       (destOut),
      .o_mem_out    (memOut),
      .o_ready      (ready),
      .o_wbuf_empty (wbufEmpty),
      .memBus       (memBus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
   } modelEntry_t;

   modelEntry_t modelQ[$];
   logic [31:0] memModel[logic [31:0]];
   logic [31:0] writeLog[$];

   int          checkCount = 0;
   int          errCount   = 0;
   int          latency    = 1;
   bit          ackEnable  = 1'b1;
   bit          ackIsRead  = 1'b0;
   bit          ackIsWrite = 1'b0;
   int          waitCnt    = 0;
   int          readAcks   = 0;
   int          writeAcks  = 0;
   logic [31:0] lastWriteAddr = '0;

   // Unwritten words read back as a fixed function of their address.
   function automatic logic [31:0] readMem(input logic [31:0] a);
      if (memModel.exists(a)) return memModel[a];
      return a ^ 32'hA5A5_0000;
   endfunction

   function automatic logic [31:0] effOf(input logic [31:0] byteAddr);
      logic [31:0] aligned;
      aligned = byteAddr & 32'hFFFF_FFFC;
      return aligned - 32'd1024;
   endfunction

   task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checkCount++;
      if (act !== exp) begin
         errCount++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
      end
   endtask

   task automatic applyStimulus(input logic isLoad, input logic isStore, input logic [31:0] addr,
                                input logic [31:0] data, input logic [3:0] rd);
      wbEn   = isLoad;
      rEn    = isLoad;
      wEn    = isStore;
      aluRes = addr;
      valRm  = data;
      dest   = rd;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic waitReady(input string nm, input int maxCyc);
      int n;
      n = 0;
      @(negedge clk);
      while (ready !== 1'b1 && n < maxCyc) begin
         @(negedge clk);
         n++;
      end
      if (ready !== 1'b1) begin
         checkCount++;
         errCount++;
         $display("[TB] FAIL %s: ready=0 after %0d cycles, expected 1", nm, maxCyc);
      end
   endtask

   task automatic waitDrained(input string nm, input int maxCyc);
      int n;
      n = 0;
      @(negedge clk);
      while (!(wbufEmpty === 1'b1 && memBus.mem_req === 1'b0) && n < maxCyc) begin
         @(negedge clk);
         n++;
      end
      if (!(wbufEmpty === 1'b1 && memBus.mem_req === 1'b0)) begin
         checkCount++;
         errCount++;
         $display("[TB] FAIL %s: empty=%0b req=%0b after %0d cycles, expected 1/0",
                  nm, wbufEmpty, memBus.mem_req, maxCyc);
      end
   endtask

   // Controller model: acks a held request after 'latency' extra cycles, one-cycle pulse.
   initial begin
      memBus.mem_ack   = 1'b0;
      memBus.mem_rdata = '0;
      forever begin
         @(posedge clk);
         #1;
         if (!rst_n) begin
            memBus.mem_ack = 1'b0;
            waitCnt        = 0;
         end else if (memBus.mem_ack) begin
            memBus.mem_ack = 1'b0;
            waitCnt        = 0;
         end else if (memBus.mem_req && ackEnable) begin
            waitCnt++;
            if (waitCnt > latency) begin
               memBus.mem_ack = 1'b1;
               ackIsWrite     = memBus.mem_we;
               ackIsRead      = !memBus.mem_we;
               if (memBus.mem_we) begin
                  writeAcks++;
                  lastWriteAddr    = memBus.mem_addr;
                  memBus.mem_rdata = '0;
               end else begin
                  readAcks++;
                  memBus.mem_rdata = readMem(memBus.mem_addr);
               end
            end
         end else if (!memBus.mem_req) begin
            waitCnt = 0;
         end
      end
   end

   // Per-cycle compare against the buffer/memory model, then advance the model to the next edge.
   always @(negedge clk) begin
      logic [31:0] eff;
      logic [31:0] hitData;
      logic [31:0] expOut;
      bit          hit;
      bit          expReady;
      if (!rst_n) begin
         modelQ.delete();
      end else begin
         eff     = effOf(aluRes);
         hit     = 1'b0;
         hitData = '0;
         foreach (modelQ[k]) begin
            if (modelQ[k].addr == eff) begin
               hit     = 1'b1;
               hitData = modelQ[k].data;
            end
         end
         expReady = 1'b1;
         expOut   = '0;
         if (wEn) begin
            expReady = (modelQ.size() < DEPTH);
         end else if (rEn) begin
            if (hit) expOut = hitData;
            else if (memBus.mem_ack && ackIsRead) expOut = readMem(eff);
            else expReady = 1'b0;
         end
         checkOutput("ready", ready, expReady);
         checkOutput("memOut", memOut, expOut);
         checkOutput("wbufEmpty", wbufEmpty, modelQ.size() == 0);
         checkOutput("wbEnCopy", wbEnOut, wbEn);
         checkOutput("rEnCopy", rEnOut, rEn);
         checkOutput("aluCopy", aluResOut, aluRes);
         checkOutput("destCopy", destOut, dest);
         if (memBus.mem_req && !memBus.mem_we) begin
            checkOutput("readReqLegal", rEn && !hit, 1);
         end
         if (memBus.mem_req && memBus.mem_we) begin
            checkOutput("writeReqLegal", modelQ.size() != 0, 1);
            if (modelQ.size() != 0) checkOutput("drainHeadAddr", memBus.mem_addr, modelQ[0].addr);
         end
         if (memBus.mem_ack) begin
            checkOutput("ackWhileReq", memBus.mem_req, 1);
            if (ackIsWrite) begin
               if (modelQ.size() == 0) begin
                  checkCount++;
                  errCount++;
                  $display("[TB] FAIL drainUnexpected: write ack with model depth 0, expected depth >= 1");
               end else begin
                  checkOutput("drainAddr", memBus.mem_addr, modelQ[0].addr);
                  checkOutput("drainData", memBus.mem_wdata, modelQ[0].data);
                  memModel[modelQ[0].addr] = modelQ[0].data;
                  writeLog.push_back(memBus.mem_wdata);
                  void'(modelQ.pop_front());
               end
            end
            if (ackIsRead) begin
               checkOutput("readAddr", memBus.mem_addr, eff);
               checkOutput("readForMiss", rEn && !hit, 1);
            end
         end
         if (wEn && expReady) begin
            modelQ.push_back('{addr: eff, data: valRm});
         end
      end
   end

   // Watchdog so the run always terminates.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached, expected $finish earlier");
      $fatal(1, "[TB] watchdog");
   end

   // Directed scenarios with literal expectations.
   initial begin
      int readsBefore;
      int writesBefore;
      int n;
      rst_n = 1'b0;
      applyStimulus(0, 0, 32'd0, 32'd0, 4'd0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      // Reset state
      @(negedge clk);
      checkOutput("rstReady", ready, 1);
      checkOutput("rstEmpty", wbufEmpty, 1);
      checkOutput("rstMemOut", memOut, 0);
      checkOutput("rstMemReq", memBus.mem_req, 0);
      readsBefore = readAcks;

      // Store then load hit, forwarded with no read request
      tick();
      applyStimulus(0, 1, 32'd1028, 32'hDEAD_BEEF, 4'd3);
      @(negedge clk);
      checkOutput("storeReady", ready, 1);
      tick();
      applyStimulus(1, 0, 32'd1028, 32'd0, 4'd5);
      @(negedge clk);
      checkOutput("hitData", memOut, 32'hDEAD_BEEF);
      checkOutput("hitReady", ready, 1);
      tick();
      applyStimulus(0, 0, 32'd0, 32'd0, 4'd0);
      waitDrained("drainHit", 50);
      checkOutput("noReadOnHit", readAcks, readsBefore);

      // Buffer full: five stores with acks held off
      ackEnable = 1'b0;
      tick();
      for (int i = 0; i < DEPTH; i++) begin
         applyStimulus(0, 1, 32'd1100 + 32'(4 * i), 32'h100 + 32'(i), 4'd0);
         @(negedge clk);
         checkOutput("fillReady", ready, 1);
         tick();
      end
      applyStimulus(0, 1, 32'd1116, 32'h104, 4'd0);
      @(negedge clk);
      checkOutput("fullStall", ready, 0);
      writesBefore = writeAcks;
      latency   = 0;
      ackEnable = 1'b1;
      waitReady("fullRelease", 20);
      checkOutput("fullOneAck", writeAcks - writesBefore, 1);
      tick();
      applyStimulus(0, 0, 32'd0, 32'd0, 4'd0);
      @(negedge clk);
      checkOutput("fullNotEmpty", wbufEmpty, 0);
      waitDrained("drainFull", 100);

      // Load miss behind an in-flight write, controller latency 3
      latency      = 3;
      writesBefore = writeAcks;
      readsBefore  = readAcks;
      tick();
      applyStimulus(0, 1, 32'd4000, 32'h0000_4444, 4'd0);
      tick();
      applyStimulus(0, 0, 32'd0, 32'd0, 4'd0);
      tick();
      applyStimulus(1, 0, 32'd2048, 32'd0, 4'd7);
      waitReady("missRelease", 30);
      checkOutput("missData", memOut, 32'hA5A5_0400);
      checkOutput("missAddr", memBus.mem_addr, 32'h0000_0400);
      checkOutput("missWe", memBus.mem_we, 0);
      checkOutput("missWriteFirst", writeAcks - writesBefore, 1);
      checkOutput("missOneRead", readAcks - readsBefore, 1);
      tick();
      applyStimulus(0, 0, 32'd0, 32'd0, 4'd0);
      waitDrained("drainMiss", 50);

      // Youngest match and in-order drain
      latency = 2;
      tick();
      applyStimulus(0, 1, 32'd1200, 32'd1, 4'd0);
      tick();
      applyStimulus(0, 1, 32'd1200, 32'd2, 4'd0);
      tick();
      applyStimulus(1, 0, 32'd1200, 32'd0, 4'd2);
      @(negedge clk);
      checkOutput("youngestData", memOut, 32'd2);
      checkOutput("youngestReady", ready, 1);
      tick();
      applyStimulus(0, 0, 32'd0, 32'd0, 4'd0);
      waitDrained("drainYoung", 60);
      n = writeLog.size();
      checkOutput("drainLogLen", n >= 2, 1);
      if (n >= 2) begin
         checkOutput("drainFirst", writeLog[n-2], 32'd1);
         checkOutput("drainSecond", writeLog[n-1], 32'd2);
      end

      // Address translation and wrap-around
      tick();
      applyStimulus(0, 1, 32'd1027, 32'h11, 4'd0);
      tick();
      applyStimulus(0, 0, 32'd0, 32'd0, 4'd0);
      waitDrained("drainXlate", 50);
      checkOutput("xlate1027", lastWriteAddr, 32'd0);
      tick();
      applyStimulus(1, 0, 32'd0, 32'd0, 4'd1);
      waitReady("wrapRelease", 30);
      checkOutput("xlateWrap", memBus.mem_addr, 32'hFFFF_FC00);
      checkOutput("wrapData", memOut, 32'h5A5A_FC00);
      tick();
      applyStimulus(1, 0, 32'd1026, 32'd0, 4'd1);
      waitReady("rereadRelease", 30);
      checkOutput("rereadData", memOut, 32'h11);
      tick();
      applyStimulus(0, 0, 32'd0, 32'd0, 4'd0);
      waitDrained("drainReread", 50);

      // Asynchronous reset in the middle of a write transaction
      ackEnable = 1'b0;
      tick();
      applyStimulus(0, 1, 32'd1300, 32'h77, 4'd0);
      tick();
      applyStimulus(0, 0, 32'd0, 32'd0, 4'd0);
      tick();
      @(negedge clk);
      checkOutput("preResetReq", memBus.mem_req, 1);
      #2;
      rst_n = 1'b0;
      modelQ.delete();
      #1;
      checkOutput("asyncRstReq", memBus.mem_req, 0);
      checkOutput("asyncRstEmpty", wbufEmpty, 1);
      checkOutput("asyncRstReady", ready, 1);
      checkOutput("asyncRstMemOut", memOut, 0);
      repeat (2) @(posedge clk);
      #1;
      rst_n     = 1'b1;
      ackEnable = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checkOutput("postRstReq", memBus.mem_req, 0);
         checkOutput("postRstEmpty", wbufEmpty, 1);
      end

      $display("Result: errors=%0d of %0d checks", errCount, checkCount);
      $finish;
   end

endmodule
